pipe_ctrl: RTL and testbench

//  Central valid/allowin sequencer for the 5-stage pipeline (IF->ID->EX->MEM->WB).

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_stage_cell.sv | 35 +++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline valid/allowin sequencer: reset level,
// sequencer states, stage count and hold-counter width.
package pipe_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b0;
  localparam int   NUM_STAGES = 4;
  localparam int   HOLD_W     = 4;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_stage_cell.sv
// One pipeline stage: owns its valid bit, derives its allowin from the stage
// below, and produces the latch enable of the bus register feeding it.
module pipe_stage_cell
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic prev_valid,
  input  logic prev_ready_go,
  input  logic ready_go,
  input  logic next_allowin,
  output logic valid,
  output logic allowin,
  output logic we
);

  logic incoming;

  assign incoming = prev_valid & prev_ready_go;
  // An empty slot always accepts, so bubbles collapse under backpressure.
  assign allowin  = ~valid | (ready_go & next_allowin);
  assign we       = incoming & allowin & ~flush;

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (allowin) begin
      valid <= incoming;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central valid/allowin sequencer for the IF->ID->EX->MEM->WB pipeline, plus the
// flush/refill sequencing after a WB-committed exception or ertn.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid_i,
  input  logic             id_ready_go_i,
  input  logic             ex_ready_go_i,
  input  logic             mem_ready_go_i,
  input  logic             wb_ready_go_i,
  input  logic             wb_excp_i,
  input  logic             wb_ertn_i,
  output logic             if_allowin_o,
  output logic             id_allowin_o,
  output logic             ex_allowin_o,
  output logic             mem_allowin_o,
  output logic             wb_allowin_o,
  output logic             id_valid_o,
  output logic             ex_valid_o,
  output logic             mem_valid_o,
  output logic             wb_valid_o,
  output logic             id_we_o,
  output logic             ex_we_o,
  output logic             mem_we_o,
  output logic             wb_we_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  pc_state_e         state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              run;
  logic [CNT_W-1:0]  retire_cnt;

  assign run          = (state == PC_RUN);
  assign if_allowin_o = id_allowin_o & run;
  assign flush_o      = wb_valid_o & (wb_excp_i | wb_ertn_i);
  assign retire_cnt_o = retire_cnt;

  // While holding after a flush, ID must load bubbles even though it has room.
  pipe_stage_cell u_id (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush_o),
    .prev_valid    (if_valid_i),
    .prev_ready_go (run),
    .ready_go      (id_ready_go_i),
    .next_allowin  (ex_allowin_o),
    .valid         (id_valid_o),
    .allowin       (id_allowin_o),
    .we            (id_we_o)
  );

  pipe_stage_cell u_ex (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush_o),
    .prev_valid    (id_valid_o),
    .prev_ready_go (id_ready_go_i),
    .ready_go      (ex_ready_go_i),
    .next_allowin  (mem_allowin_o),
    .valid         (ex_valid_o),
    .allowin       (ex_allowin_o),
    .we            (ex_we_o)
  );

  pipe_stage_cell u_mem (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush_o),
    .prev_valid    (ex_valid_o),
    .prev_ready_go (ex_ready_go_i),
    .ready_go      (mem_ready_go_i),
    .next_allowin  (wb_allowin_o),
    .valid         (mem_valid_o),
    .allowin       (mem_allowin_o),
    .we            (mem_we_o)
  );

  pipe_stage_cell u_wb (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush_o),
    .prev_valid    (mem_valid_o),
    .prev_ready_go (mem_ready_go_i),
    .ready_go      (wb_ready_go_i),
    .next_allowin  (1'b1),
    .valid         (wb_valid_o),
    .allowin       (wb_allowin_o),
    .we            (wb_we_o)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      state    <= PC_RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // A flush seen in HOLD cannot normally happen; if it does, the hold restarts.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    if (flush_o) begin
      state_next    = PC_HOLD;
      hold_cnt_next = HOLD_W'(FLUSH_CYCLES - 1);
    end else if (state == PC_HOLD) begin
      if (hold_cnt == '0) begin
        state_next = PC_RUN;
      end else begin
        hold_cnt_next = hold_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      retire_cnt <= '0;
    end else if (wb_valid_o & wb_ready_go_i & ~flush_o) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against an instruction-slot model of the pipeline.
module tb_pipe_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             if_valid_i, id_ready_go_i, ex_ready_go_i, mem_ready_go_i, wb_ready_go_i;
  logic             wb_excp_i, wb_ertn_i;
  logic             if_allowin_o, id_allowin_o, ex_allowin_o, mem_allowin_o, wb_allowin_o;
  logic             id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o;
  logic             id_we_o, ex_we_o, mem_we_o, wb_we_o;
  logic             flush_o;
  logic [CNT_W-1:0] retire_cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid_i     (if_valid_i),
    .id_ready_go_i  (id_ready_go_i),
    .ex_ready_go_i  (ex_ready_go_i),
    .mem_ready_go_i (mem_ready_go_i),
    .wb_ready_go_i  (wb_ready_go_i),
    .wb_excp_i      (wb_excp_i),
    .wb_ertn_i      (wb_ertn_i),
    .if_allowin_o   (if_allowin_o),
    .id_allowin_o   (id_allowin_o),
    .ex_allowin_o   (ex_allowin_o),
    .mem_allowin_o  (mem_allowin_o),
    .wb_allowin_o   (wb_allowin_o),
    .id_valid_o     (id_valid_o),
    .ex_valid_o     (ex_valid_o),
    .mem_valid_o    (mem_valid_o),
    .wb_valid_o     (wb_valid_o),
    .id_we_o        (id_we_o),
    .ex_we_o        (ex_we_o),
    .mem_we_o       (mem_we_o),
    .wb_we_o        (wb_we_o),
    .flush_o        (flush_o),
    .retire_cnt_o   (retire_cnt_o)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model: each slot holds an instruction tag (0 = empty); index 0=ID .. 3=WB.
  int          slot [4];
  int          next_tag;
  int          hold_left;
  logic [31:0] m_retire;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) slot[k] = 0;
    next_tag  = 1;
    hold_left = 0;
    m_retire  = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model.
  task automatic applyStimulus(input logic ifv, input logic [3:0] rg,
                               input logic excp, input logic ertn, input logic rstn);
    bit free [4];
    bit leaves [4];
    bit e_flush, e_if_allow;
    bit e_we [4];
    int nslot [4];

    @(negedge clk);
    rst_n          = rstn;
    if_valid_i     = ifv;
    id_ready_go_i  = rg[0];
    ex_ready_go_i  = rg[1];
    mem_ready_go_i = rg[2];
    wb_ready_go_i  = rg[3];
    wb_excp_i      = excp;
    wb_ertn_i      = ertn;
    #1;

    e_flush = (slot[3] != 0) && (excp || ertn);
    // A slot frees up if it is empty or its occupant moves on this cycle.
    for (int k = 3; k >= 0; k--) begin
      leaves[k] = (slot[k] != 0) && rg[k] && ((k == 3) ? 1'b1 : free[k+1]);
      free[k]   = (slot[k] == 0) || leaves[k];
    end
    e_if_allow = free[0] && (hold_left == 0);
    e_we[0] = ifv && e_if_allow && !e_flush;
    for (int k = 1; k < 4; k++) e_we[k] = (slot[k-1] != 0) && rg[k-1] && free[k] && !e_flush;

    checkOutput("flush",      32'(flush_o),       32'(e_flush));
    checkOutput("if_allowin", 32'(if_allowin_o),  32'(e_if_allow));
    checkOutput("id_allowin", 32'(id_allowin_o),  32'(free[0]));
    checkOutput("ex_allowin", 32'(ex_allowin_o),  32'(free[1]));
    checkOutput("mem_allowin",32'(mem_allowin_o), 32'(free[2]));
    checkOutput("wb_allowin", 32'(wb_allowin_o),  32'(free[3]));
    checkOutput("id_valid",   32'(id_valid_o),    32'(slot[0] != 0));
    checkOutput("ex_valid",   32'(ex_valid_o),    32'(slot[1] != 0));
    checkOutput("mem_valid",  32'(mem_valid_o),   32'(slot[2] != 0));
    checkOutput("wb_valid",   32'(wb_valid_o),    32'(slot[3] != 0));
    checkOutput("id_we",      32'(id_we_o),       32'(e_we[0]));
    checkOutput("ex_we",      32'(ex_we_o),       32'(e_we[1]));
    checkOutput("mem_we",     32'(mem_we_o),      32'(e_we[2]));
    checkOutput("wb_we",      32'(wb_we_o),       32'(e_we[3]));
    checkOutput("retire_cnt", retire_cnt_o,       m_retire);

    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else if (e_flush) begin
      for (int k = 0; k < 4; k++) slot[k] = 0;
      hold_left = FLUSH_CYCLES;
    end else begin
      if (leaves[3]) m_retire = m_retire + 1;
      for (int k = 3; k >= 1; k--)
        nslot[k] = free[k] ? (((slot[k-1] != 0) && rg[k-1]) ? slot[k-1] : 0) : slot[k];
      nslot[0] = slot[0];
      if (free[0]) begin
        if (ifv && hold_left == 0) begin
          nslot[0] = next_tag;
          next_tag++;
        end else begin
          nslot[0] = 0;
        end
      end
      for (int k = 0; k < 4; k++) slot[k] = nslot[k];
      if (hold_left > 0) hold_left--;
    end
  endtask

  initial begin
    rst_n = 1'b0; if_valid_i = 1'b0;
    id_ready_go_i = 1'b1; ex_ready_go_i = 1'b1; mem_ready_go_i = 1'b1; wb_ready_go_i = 1'b1;
    wb_excp_i = 1'b0; wb_ertn_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Exception with an empty WB stage must be ignored.
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1);

    // Clean restart, then a free-flowing pipe for 10 cycles.
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
      #1;
      if (i == 3) checkOutput("t1_wb_valid_c3", 32'(wb_valid_o), 32'd0);
      if (i == 4) checkOutput("t1_wb_valid_c4", 32'(wb_valid_o), 32'd1);
      if (i >= 4) checkOutput("t1_we_all", 32'({id_we_o, ex_we_o, mem_we_o, wb_we_o}), 32'hf);
    end
    checkOutput("t1_retire_c10", retire_cnt_o, 32'd6);

    // EX stall for 3 cycles, then resume.
    repeat (3) applyStimulus(1'b1, 4'b1101, 1'b0, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);

    // WB backpressure with a full pipe.
    repeat (3) applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Exception in WB, then refill.
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
    repeat (6) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Reset for one cycle mid-stream.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Random traffic with mostly-ready stages and occasional exceptions/resets.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rg;
      for (int k = 0; k < 4; k++) rg[k] = ($urandom_range(0, 9) < 8);
      applyStimulus(($urandom_range(0, 9) < 8), rg,
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
